// File: rtl/calc_entry_sequencer.sv
// Entry sequencer for the 4-bit calculator: debounced three-press operand/opcode entry,
// valid/ready issue, response capture. Optional accumulator chaining: CALC_SEQ_CHAIN_EN.
module calc_entry_sequencer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_in,
  input  logic             enter,
  input  logic             abort,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_a,
  output logic [WIDTH-1:0] req_b,
  output logic [1:0]       req_op,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] display,
  output logic             result_valid,
  output logic [2:0]       state_out,
  output logic [7:0]       op_count
);

  typedef enum logic [2:0] {
    StA     = 3'b000,
    StB     = 3'b001,
    StOp    = 3'b010,
    StIssue = 3'b011,
    StWait  = 3'b100,
    StShow  = 3'b101
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_enter_filt;
  logic [7:0]       r_db_cnt;
  logic             r_press;
  logic [WIDTH-1:0] r_req_a;
  logic [WIDTH-1:0] r_req_b;
  logic [1:0]       r_req_op;
  logic [WIDTH-1:0] r_display;
  logic             r_result_valid;
  logic [7:0]       r_op_count;

  logic w_db_mismatch;
  logic w_db_hit;
  logic w_load_a;
  logic w_load_b;
  logic w_load_op;
  logic w_capture;
`ifdef CALC_SEQ_CHAIN_EN
  logic w_chain;
`endif

  assign w_db_mismatch = (enter != r_enter_filt);
  assign w_db_hit      = w_db_mismatch &&
                         (({1'b0, r_db_cnt} + 9'd1) == 9'(DEBOUNCE_CYCLES));

  // Debounce filter; the press pulse is registered off the filtered rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_enter_filt <= 1'b0;
      r_db_cnt     <= 8'd0;
      r_press      <= 1'b0;
    end else begin
      if (!w_db_mismatch) begin
        r_db_cnt <= 8'd0;
      end else if (w_db_hit) begin
        r_db_cnt     <= 8'd0;
        r_enter_filt <= ~r_enter_filt;
      end else begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
      r_press <= w_db_hit && !r_enter_filt;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_capture    = 1'b0;
`ifdef CALC_SEQ_CHAIN_EN
    w_chain      = 1'b0;
`endif
    case (r_state)
      StA: begin
        if (abort) begin
          w_state_next = StA;
        end else if (r_press) begin
          w_load_a     = 1'b1;
          w_state_next = StB;
        end
      end
      StB: begin
        if (abort) begin
          w_state_next = StA;
        end else if (r_press) begin
          w_load_b     = 1'b1;
          w_state_next = StOp;
        end
      end
      StOp: begin
        if (abort) begin
          w_state_next = StA;
        end else if (r_press) begin
          w_load_op    = 1'b1;
          w_state_next = StIssue;
        end
      end
      // Abort and presses are ignored until the request has been accepted.
      StIssue: begin
        if (req_ready) w_state_next = StWait;
      end
      StWait: begin
        if (rsp_valid) begin
          w_capture    = 1'b1;
          w_state_next = StShow;
        end
      end
      StShow: begin
        if (abort) begin
          w_state_next = StA;
        end else if (r_press) begin
`ifdef CALC_SEQ_CHAIN_EN
          w_chain      = 1'b1;
          w_state_next = StB;
`else
          w_state_next = StA;
`endif
        end
      end
      default: w_state_next = StA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= StA;
      r_req_a        <= '0;
      r_req_b        <= '0;
      r_req_op       <= 2'b00;
      r_display      <= '0;
      r_result_valid <= 1'b0;
      r_op_count     <= 8'd0;
    end else begin
      r_state        <= w_state_next;
      r_result_valid <= w_capture;
      if (w_load_a) begin
        r_req_a   <= data_in;
        r_display <= data_in;
      end
      if (w_load_b) begin
        r_req_b   <= data_in;
        r_display <= data_in;
      end
      if (w_load_op) begin
        r_req_op  <= op_in;
        r_display <= {{(WIDTH-2){1'b0}}, op_in};
      end
      if (w_capture) begin
        r_display  <= rsp_data;
        r_op_count <= r_op_count + 8'd1;
      end
`ifdef CALC_SEQ_CHAIN_EN
      // Display still holds the result in StShow, so it seeds the next operand A.
      if (w_chain) r_req_a <= r_display;
`endif
    end
  end

  assign req_valid    = (r_state == StIssue);
  assign req_a        = r_req_a;
  assign req_b        = r_req_b;
  assign req_op       = r_req_op;
  assign display      = r_display;
  assign result_valid = r_result_valid;
  assign state_out    = r_state;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed self-checking bench for calc_entry_sequencer with a behavioural calculator responder.
module tb_calc_entry_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic [1:0] op_in;
  logic       enter;
  logic       abort;
  logic       req_ready;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       req_valid;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_op;
  logic [3:0] display;
  logic       result_valid;
  logic [2:0] state_out;
  logic [7:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic stray     = 1'b0;
  logic rsp_pulse = 1'b0;
  logic hs_n      = 1'b0;
  logic [3:0] hs_val = 4'd0;
  int   rsp_cnt   = 0;

  calc_entry_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .op_in       (op_in),
    .enter       (enter),
    .abort       (abort),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .display     (display),
    .result_valid(result_valid),
    .state_out   (state_out),
    .op_count    (op_count)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] calc(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] o);
    case (o)
      2'd0:    return 4'(a + b);
      2'd1:    return 4'(a - b);
      2'd2:    return a | b;
      default: return {3'b000, (a != b)};
    endcase
  endfunction

  // Calculator model: answers three cycles after each accepted request.
  assign rsp_valid = rsp_pulse | stray;

  always @(negedge clock) begin
    hs_n   = req_valid & req_ready;
    hs_val = calc(req_a, req_b, req_op);
  end

  always @(posedge clock) begin
    logic fire;
    logic emit;
    fire = hs_n;
    #1;
    emit = (rsp_cnt == 1);
    if (rsp_cnt > 0) rsp_cnt = rsp_cnt - 1;
    if (fire) begin
      rsp_cnt  = 3;
      rsp_data = hs_val;
    end
    rsp_pulse = emit;
  end

  task automatic do_press(input logic [3:0] d, input logic [1:0] o);
    data_in = d;
    op_in   = o;
    enter   = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    enter = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clock);
    #1;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state_out); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
    n_cmp++; if (display !== 4'd0) begin n_fail++; $display("FAIL rst_display got %0d want 0", display); end
    n_cmp++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL rst_op_count got %0d want 0", op_count); end
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid got %b want 0", result_valid); end
    n_cmp++; if ({req_a, req_b, req_op} !== 10'd0) begin n_fail++; $display("FAIL rst_req_fields got %h want 0", {req_a, req_b, req_op}); end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    req_ready = 1'b0;
    do_press(4'd3, 2'd0); settle();
    n_cmp++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL basic_state_b got %0d want 1", state_out); end
    n_cmp++; if (display !== 4'd3) begin n_fail++; $display("FAIL basic_disp_a got %0d want 3", display); end
    do_press(4'd5, 2'd0); settle();
    n_cmp++; if (state_out !== 3'd2) begin n_fail++; $display("FAIL basic_state_op got %0d want 2", state_out); end
    n_cmp++; if (display !== 4'd5) begin n_fail++; $display("FAIL basic_disp_b got %0d want 5", display); end
    do_press(4'd0, 2'd0);
    n_cmp++; if (state_out !== 3'd3) begin n_fail++; $display("FAIL basic_state_issue got %0d want 3", state_out); end
    n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid got %b want 1", req_valid); end
    n_cmp++; if ({req_a, req_b, req_op} !== {4'd3, 4'd5, 2'd0}) begin n_fail++; $display("FAIL basic_req_fields got %h want %h", {req_a, req_b, req_op}, {4'd3, 4'd5, 2'd0}); end
    req_ready = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (state_out !== 3'd4) begin n_fail++; $display("FAIL basic_state_wait got %0d want 4", state_out); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", req_valid); end
    wait_result(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_result_timeout got %b want 1", ok); end
    n_cmp++; if (display !== 4'd8) begin n_fail++; $display("FAIL basic_result got %0d want 8", display); end
    n_cmp++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL basic_op_count got %0d want 1", op_count); end
    n_cmp++; if (state_out !== 3'd5) begin n_fail++; $display("FAIL basic_state_show got %0d want 5", state_out); end
    @(posedge clock);
    #1;
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %b want 0", result_valid); end
    settle();
    do_press(4'd0, 2'd0);
`ifdef CALC_SEQ_CHAIN_EN
    n_cmp++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL chain_state got %0d want 1", state_out); end
    n_cmp++; if (req_a !== 4'd8) begin n_fail++; $display("FAIL chain_req_a got %0d want 8", req_a); end
    settle();
    pulse_abort();
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL chain_abort_state got %0d want 0", state_out); end
`else
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL show_exit_state got %0d want 0", state_out); end
    n_cmp++; if (req_a !== 4'd3) begin n_fail++; $display("FAIL show_exit_req_a got %0d want 3", req_a); end
    settle();
`endif
    n_cmp++; if (display !== 4'd8) begin n_fail++; $display("FAIL show_exit_display got %0d want 8", display); end
  endtask

  task automatic test_debounce();
    data_in = 4'd9;
    for (int r = 0; r < 10; r++) begin
      enter = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      enter = 1'b0;
      @(posedge clock);
      #1;
    end
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL db_glitch_state got %0d want 0", state_out); end
    enter = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    enter = 1'b0;
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL db_edge4_state got %0d want 0", state_out); end
    @(posedge clock);
    #1;
    n_cmp++; if (state_out !== 3'd1) begin n_fail++; $display("FAIL db_edge5_state got %0d want 1", state_out); end
    n_cmp++; if (req_a !== 4'd9) begin n_fail++; $display("FAIL db_req_a got %0d want 9", req_a); end
    settle();
  endtask

  task automatic test_backpressure();
    bit ok;
    req_ready = 1'b0;
    do_press(4'd4, 2'd0); settle();
    do_press(4'd0, 2'd1);
    for (int i = 0; i < 20; i++) begin
      abort = (i % 2 == 1);
      enter = ((i % 10) < 5);
      @(posedge clock);
      #1;
      n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, req_valid); end
      n_cmp++; if ({req_a, req_b, req_op} !== {4'd9, 4'd4, 2'd1}) begin n_fail++; $display("FAIL bp_fields[%0d] got %h want %h", i, {req_a, req_b, req_op}, {4'd9, 4'd4, 2'd1}); end
      n_cmp++; if (state_out !== 3'd3) begin n_fail++; $display("FAIL bp_state[%0d] got %0d want 3", i, state_out); end
    end
    abort = 1'b0;
    enter = 1'b0;
    settle();
    req_ready = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (state_out !== 3'd4) begin n_fail++; $display("FAIL bp_state_wait got %0d want 4", state_out); end
    wait_result(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_result_timeout got %b want 1", ok); end
    n_cmp++; if (display !== 4'd5) begin n_fail++; $display("FAIL bp_result got %0d want 5", display); end
    n_cmp++; if (op_count !== 8'd2) begin n_fail++; $display("FAIL bp_op_count got %0d want 2", op_count); end
    pulse_abort();
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL show_abort_state got %0d want 0", state_out); end
    n_cmp++; if (display !== 4'd5) begin n_fail++; $display("FAIL show_abort_display got %0d want 5", display); end
  endtask

  task automatic test_abort();
    do_press(4'd7, 2'd0); settle();
    do_press(4'd2, 2'd0); settle();
    pulse_abort();
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL abort_op_state got %0d want 0", state_out); end
    n_cmp++; if (display !== 4'd2) begin n_fail++; $display("FAIL abort_op_display got %0d want 2", display); end
    n_cmp++; if ({req_a, req_b} !== {4'd7, 4'd2}) begin n_fail++; $display("FAIL abort_op_regs got %h want 72", {req_a, req_b}); end
    do_press(4'd6, 2'd0); settle();
    data_in = 4'd11;
    enter   = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL abort_press_state got %0d want 0", state_out); end
    n_cmp++; if (req_b !== 4'd2) begin n_fail++; $display("FAIL abort_press_req_b got %0d want 2", req_b); end
    abort = 1'b0;
    enter = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    do_press(4'd1, 2'd0); settle();
    do_press(4'd1, 2'd0); settle();
    do_press(4'd0, 2'd2);
    n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b want 1", req_valid); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", req_valid); end
    n_cmp++; if (state_out !== 3'd0) begin n_fail++; $display("FAIL rmid_state got %0d want 0", state_out); end
    n_cmp++; if ({req_a, req_b, req_op, display, op_count} !== 22'd0) begin n_fail++; $display("FAIL rmid_outputs got %h want 0", {req_a, req_b, req_op, display, op_count}); end
    stray = 1'b1;
    @(posedge clock);
    #1;
    stray = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL stray_result_valid got %b want 0", result_valid); end
    @(posedge clock);
    #1;
    n_cmp++; if ({state_out, display} !== 7'd0) begin n_fail++; $display("FAIL stray_state_disp got %h want 0", {state_out, display}); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] o;
    logic [3:0] exp;
    req_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a   = 4'(i);
      b   = 4'(i * 3 + 1);
      o   = 2'(i);
      exp = calc(a, b, o);
      do_press(a, 2'd0); settle();
      do_press(b, 2'd0); settle();
      do_press(4'd0, o);
      wait_result(ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout[%0d] got %b want 1", i, ok); end
      n_cmp++; if (display !== exp) begin n_fail++; $display("FAIL wrap_result[%0d] got %0d want %0d", i, display, exp); end
      if (i == 254) begin
        n_cmp++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL wrap_count_255 got %0d want 255", op_count); end
      end
      pulse_abort();
    end
    n_cmp++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_count_0 got %0d want 0", op_count); end
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = 4'd0;
    op_in     = 2'd0;
    enter     = 1'b0;
    abort     = 1'b0;
    req_ready = 1'b0;
    rsp_data  = 4'd0;
    test_reset();
    test_basic();
    test_debounce();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
